serv_csr_mi: RTL and testbench

Digit-serial machine-mode CSR unit, successor to the single-timer-IRQ CSR block, sitting beside the serial ALU/control in the core. Parametrised datapath width W (1/2/4/8 bits per beat). Supports three interrupt sources (software, timer, external) with a full mie/mip pair, fixed priority, and readable/writable MPIE. Register-file-backed CSRs (mscratch, mtvec, mepc, mtval) pass through i_rf_csr_out.

---
 rtl/serv_csr_mi.sv | 172 +++++++++++++++++
 tb/tb_serv_csr_mi.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_csr_mi.sv
// Digit-serial machine-mode CSR unit: mstatus, mie, mip and mcause with three
// prioritised interrupt sources; register-file CSRs pass through i_rf_csr_out.
module serv_csr_mi #(
    parameter     RESET_STRATEGY = "MINI",
    parameter int W = 1,
    parameter int B = W - 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [4:0] i_cnt,
    input  logic       i_cnt_done,
    input  logic       i_trig_irq,
    input  logic       i_msip,
    input  logic       i_mtip,
    input  logic       i_meip,
    input  logic       i_trap,
    input  logic       i_mret,
    input  logic       i_e_op,
    input  logic       i_ebreak,
    input  logic       i_mem_op,
    input  logic       i_mem_cmd,
    input  logic       i_mstatus_en,
    input  logic       i_mie_en,
    input  logic       i_mip_en,
    input  logic       i_mcause_en,
    input  logic [1:0] i_csr_source,
    input  logic       i_csr_d_sel,
    input  logic [B:0] i_rf_csr_out,
    input  logic [B:0] i_csr_imm,
    input  logic [B:0] i_rs1,
    output logic [B:0] o_csr_in,
    output logic [B:0] o_q,
    output logic       o_new_irq,
    output logic [3:0] o_irq_cause
);

    localparam bit RST_EN = (RESET_STRATEGY != "NONE");
    localparam logic [4:0] AM = ~5'(B);

    localparam logic [1:0] SRC_EXT = 2'b01;
    localparam logic [1:0] SRC_SET = 2'b10;
    localparam logic [1:0] SRC_CLR = 2'b11;

    localparam int L3  = 3 % W;
    localparam int L7  = 7 % W;
    localparam int L11 = 11 % W;
    localparam int L31 = 31 % W;

    logic       st_mie;
    logic       st_mpie;
    logic       ie_msie;
    logic       ie_mtie;
    logic       ie_meie;
    logic       mcause31;
    logic [3:0] mcause_lo;
    logic [2:0] pend_r;

    logic [2:0] pend;
    logic [2:0] rise;
    logic [3:0] cause;
    logic [3:0] exc;

    logic [B:0] d;
    logic [B:0] q_sel;
    logic [B:0] ms_b;
    logic [B:0] ie_b;
    logic [B:0] ip_b;
    logic [B:0] mc_b;

    logic       h3;
    logic       h7;
    logic       h11;
    logic       h31;
    logic [3:0] h_lo;
    logic [3:0] wd_lo;

    // Absolute bit index carried by each lane in the current beat
    for (genvar l = 0; l < W; l++) begin : g_lane
        logic [4:0] b;
        assign b = i_cnt + 5'(l);
        assign ms_b[l] = (b == 5'd3 && st_mie) || (b == 5'd7 && st_mpie)
                      || b == 5'd11 || b == 5'd12;
        assign ie_b[l] = (b == 5'd3 && ie_msie) || (b == 5'd7 && ie_mtie)
                      || (b == 5'd11 && ie_meie);
        assign ip_b[l] = (b == 5'd3 && pend_r[0]) || (b == 5'd7 && pend_r[1])
                      || (b == 5'd11 && pend_r[2]);
        assign mc_b[l] = (b == 5'd31 && mcause31)
                      || (b < 5'd4 && mcause_lo[b[1:0]]);
    end

    assign q_sel = ({W{i_mstatus_en}} & ms_b) | ({W{i_mie_en}} & ie_b)
                 | ({W{i_mip_en}} & ip_b) | ({W{i_mcause_en}} & mc_b);
    assign o_q = i_rf_csr_out | ({W{i_en}} & q_sel);
    assign d = i_csr_d_sel ? i_csr_imm : i_rs1;

    always_comb begin
        o_csr_in = o_q;
        unique case (i_csr_source)
            SRC_EXT: o_csr_in = d;
            SRC_SET: o_csr_in = o_q | d;
            SRC_CLR: o_csr_in = o_q & ~d;
            default: o_csr_in = o_q;
        endcase
    end

    // A bit is written in the beat whose aligned count covers it
    assign h3  = i_en && i_cnt == (5'd3 & AM);
    assign h7  = i_en && i_cnt == (5'd7 & AM);
    assign h11 = i_en && i_cnt == (5'd11 & AM);
    assign h31 = i_en && i_cnt == (5'd31 & AM);

    for (genvar k = 0; k < 4; k++) begin : g_lo
        assign h_lo[k]  = i_en && i_cnt == (5'(k) & AM);
        assign wd_lo[k] = o_csr_in[k % W];
    end

    assign pend = {i_meip & ie_meie, i_mtip & ie_mtie, i_msip & ie_msie}
                & {3{st_mie}};
    assign rise = pend & ~pend_r;

    always_comb begin
        cause = 4'd0;
        if (rise[2])      cause = 4'd11;
        else if (rise[0]) cause = 4'd3;
        else if (rise[1]) cause = 4'd7;
    end

    always_comb begin
        exc = 4'd0;
        if (i_e_op)        exc = i_ebreak ? 4'd3 : 4'd11;
        else if (i_mem_op) exc = i_mem_cmd ? 4'd6 : 4'd4;
    end

    always_ff @(posedge i_clk) begin
        if (i_trig_irq) begin
            pend_r      <= pend;
            o_new_irq   <= |rise;
            o_irq_cause <= cause;
        end
        if (i_trap && i_cnt_done) begin
            st_mpie   <= st_mie;
            st_mie    <= 1'b0;
            mcause31  <= o_new_irq;
            mcause_lo <= o_new_irq ? o_irq_cause : exc;
        end else if (i_mret && i_cnt_done) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else begin
            if (i_mstatus_en && h3) st_mie   <= o_csr_in[L3];
            if (i_mstatus_en && h7) st_mpie  <= o_csr_in[L7];
            if (i_mcause_en && h31) mcause31 <= o_csr_in[L31];
            for (int k = 0; k < 4; k++)
                if (i_mcause_en && h_lo[k]) mcause_lo[k] <= wd_lo[k];
        end
        if (i_mie_en && h3)  ie_msie <= o_csr_in[L3];
        if (i_mie_en && h7)  ie_mtie <= o_csr_in[L7];
        if (i_mie_en && h11) ie_meie <= o_csr_in[L11];
        // Reset overrides everything above; mcause deliberately keeps its value
        if (RST_EN && i_rst) begin
            o_new_irq   <= 1'b0;
            o_irq_cause <= 4'd0;
            pend_r      <= 3'd0;
            st_mie      <= 1'b0;
            st_mpie     <= 1'b0;
            ie_msie     <= 1'b0;
            ie_mtie     <= 1'b0;
            ie_meie     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serv_csr_mi.sv
// Bench for serv_csr_mi: four instances at W=1/2/4/8 share word-level
// stimulus; each word is serialised per width and read back per instance.
module tb_serv_csr_mi;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    localparam logic [3:0] MS = 4'b0001;
    localparam logic [3:0] IE = 4'b0010;
    localparam logic [3:0] IP = 4'b0100;
    localparam logic [3:0] MC = 4'b1000;
    localparam logic [1:0] CSR = 2'b00;
    localparam logic [1:0] EXT = 2'b01;
    localparam logic [1:0] SET = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    logic        rst;
    logic [4:0]  c;
    logic        en;
    logic [3:0]  sel;
    logic [1:0]  src;
    logic        dsel;
    logic [31:0] rs1_w;
    logic [31:0] imm_w;
    logic [31:0] rf_w;
    logic        trap;
    logic        mret;
    logic        e_op;
    logic        ebreak;
    logic        mem_op;
    logic        mem_cmd;
    logic        msip;
    logic        mtip;
    logic        meip;
    logic        trig;

    logic [3:0][31:0] rd;
    logic [3:0][31:0] wr;
    logic [3:0]       nirq;
    logic [3:0][3:0]  cause;

    int total = 0;
    int bad = 0;
    string       tq[$];
    logic [31:0] vq[$];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int WL = 1 << g;
        localparam int NB = 32 / WL;
        logic          act;
        logic          done;
        int            idx;
        logic [4:0]    cnt;
        logic [WL-1:0] rf_l;
        logic [WL-1:0] imm_l;
        logic [WL-1:0] rs1_l;
        logic [WL-1:0] ci;
        logic [WL-1:0] q;
        logic          nw;
        logic [3:0]    ca;
        logic [31:0]   acc_q;
        logic [31:0]   acc_i;

        assign act   = int'(c) < NB;
        assign done  = act && (int'(c) == NB - 1);
        assign idx   = act ? int'(c) * WL : 0;
        assign cnt   = 5'(idx);
        assign rf_l  = rf_w[idx +: WL];
        assign imm_l = imm_w[idx +: WL];
        assign rs1_l = rs1_w[idx +: WL];

        serv_csr_mi #(.RESET_STRATEGY("MINI"), .W(WL)) dut (
            .i_clk(i_clk),
            .i_rst(rst),
            .i_en(en & act),
            .i_cnt(cnt),
            .i_cnt_done(done),
            .i_trig_irq(trig),
            .i_msip(msip),
            .i_mtip(mtip),
            .i_meip(meip),
            .i_trap(trap),
            .i_mret(mret),
            .i_e_op(e_op),
            .i_ebreak(ebreak),
            .i_mem_op(mem_op),
            .i_mem_cmd(mem_cmd),
            .i_mstatus_en(sel[0]),
            .i_mie_en(sel[1]),
            .i_mip_en(sel[2]),
            .i_mcause_en(sel[3]),
            .i_csr_source(src),
            .i_csr_d_sel(dsel),
            .i_rf_csr_out(rf_l),
            .i_csr_imm(imm_l),
            .i_rs1(rs1_l),
            .o_csr_in(ci),
            .o_q(q),
            .o_new_irq(nw),
            .o_irq_cause(ca)
        );

        always @(negedge i_clk) begin
            if (act) begin
                acc_q[idx +: WL] <= q;
                acc_i[idx +: WL] <= ci;
            end
        end

        assign rd[g]    = acc_q;
        assign wr[g]    = acc_i;
        assign nirq[g]  = nw;
        assign cause[g] = ca;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        c = 5'd0; en = 0; sel = 4'd0; src = CSR; dsel = 0;
        rs1_w = '0; imm_w = '0; rf_w = '0;
        trap = 0; mret = 0; e_op = 0; ebreak = 0; mem_op = 0; mem_cmd = 0;
    endtask

    task automatic word(input string tag, input logic [3:0] s,
                        input logic [1:0] sr, input logic ds,
                        input logic [31:0] dat, input logic [31:0] rfv,
                        input logic [31:0] eq, input logic [31:0] ei);
        string t;
        logic [31:0] v;
        tq.push_back($sformatf("%s.q", tag));  vq.push_back(eq);
        tq.push_back($sformatf("%s.in", tag)); vq.push_back(ei);
        sel = s; src = sr; dsel = ds; rs1_w = dat; imm_w = dat;
        rf_w = rfv; en = 1;
        for (int k = 0; k < 32; k++) begin
            c = 5'(k);
            @(posedge i_clk); #1;
        end
        idle();
        t = tq.pop_front(); v = vq.pop_front();
        for (int n = 0; n < 4; n++) chk($sformatf("%s/w%0d", t, 1 << n), rd[n], v);
        t = tq.pop_front(); v = vq.pop_front();
        for (int n = 0; n < 4; n++) chk($sformatf("%s/w%0d", t, 1 << n), wr[n], v);
    endtask

    task automatic rd_csr(input string tag, input logic [3:0] s,
                          input logic [31:0] exp);
        word(tag, s, CSR, 1'b0, '0, '0, exp, exp);
    endtask

    task automatic irq_chk(input string tag, input logic e, input logic [3:0] cs);
        string t;
        logic [31:0] v;
        tq.push_back($sformatf("%s.new", tag));   vq.push_back({31'd0, e});
        tq.push_back($sformatf("%s.cause", tag)); vq.push_back({28'd0, cs});
        t = tq.pop_front(); v = vq.pop_front();
        for (int n = 0; n < 4; n++) chk($sformatf("%s/w%0d", t, 1 << n), {31'd0, nirq[n]}, v);
        t = tq.pop_front(); v = vq.pop_front();
        for (int n = 0; n < 4; n++) chk($sformatf("%s/w%0d", t, 1 << n), {28'd0, cause[n]}, v);
    endtask

    task automatic strobe(input string tag, input logic e, input logic [3:0] cs);
        trig = 1;
        @(posedge i_clk); #1;
        trig = 0;
        irq_chk(tag, e, cs);
    endtask

    task automatic abort_word(input logic [31:0] dat, input int at);
        sel = IE; src = EXT; rs1_w = dat; en = 1;
        for (int k = 0; k < 32; k++) begin
            c = 5'(k);
            rst = (k == at);
            @(posedge i_clk); #1;
            if (k == at) break;
        end
        rst = 0;
        idle();
    endtask

    initial begin
        idle();
        rst = 1; trig = 0; msip = 0; mtip = 0; meip = 0;
        repeat (3) @(posedge i_clk);
        #1 rst = 0;

        irq_chk("rst", 1'b0, 4'd0);
        rd_csr("rst.mstatus", MS, 32'h0000_1800);
        rd_csr("rst.mie", IE, 32'h0000_0000);

        word("csrrw.mie", IE, EXT, 1'b0, 32'h888, '0, 32'h0, 32'h888);
        rd_csr("mie", IE, 32'h0000_0888);
        word("csrrsi.mstatus", MS, SET, 1'b1, 32'h8, '0, 32'h1800, 32'h1808);
        rd_csr("mstatus", MS, 32'h0000_1808);

        msip = 1; meip = 1;
        strobe("irq.mei", 1'b1, 4'd11);
        rd_csr("mip", IP, 32'h0000_0808);

        trap = 1;
        word("trap.irq", 4'd0, CSR, 1'b0, '0, '0, '0, '0);
        rd_csr("mcause.irq", MC, 32'h8000_000B);
        rd_csr("mstatus.trap", MS, 32'h0000_1880);
        mret = 1;
        word("mret", 4'd0, CSR, 1'b0, '0, '0, '0, '0);
        rd_csr("mstatus.mret", MS, 32'h0000_1888);

        strobe("irq.held", 1'b0, 4'd0);
        meip = 0; mtip = 1;
        strobe("irq.mti", 1'b1, 4'd7);
        rd_csr("mip.mti", IP, 32'h0000_0088);
        strobe("irq.quiet", 1'b0, 4'd0);

        trap = 1; mem_op = 1; mem_cmd = 1;
        word("trap.st", 4'd0, CSR, 1'b0, '0, '0, '0, '0);
        rd_csr("mcause.st", MC, 32'h0000_0006);
        rd_csr("mstatus.st", MS, 32'h0000_1880);
        word("csrrw.mcause", MC, EXT, 1'b0, 32'hFFFF_FFFF, '0, 32'h6, 32'hFFFF_FFFF);
        rd_csr("mcause.w", MC, 32'h8000_000F);

        trap = 1; e_op = 1; ebreak = 1;
        word("trap.ebreak", 4'd0, CSR, 1'b0, '0, '0, '0, '0);
        rd_csr("mcause.ebreak", MC, 32'h0000_0003);
        trap = 1; e_op = 1;
        word("trap.ecall", 4'd0, CSR, 1'b0, '0, '0, '0, '0);
        rd_csr("mcause.ecall", MC, 32'h0000_000B);

        word("csrrc.mie", IE, CLR, 1'b0, 32'h80, '0, 32'h888, 32'h808);
        rd_csr("mie.clr", IE, 32'h0000_0808);
        word("csrrw.mip", IP, EXT, 1'b0, 32'hFFFF_FFFF, '0, 32'h88, 32'hFFFF_FFFF);
        rd_csr("mip.ro", IP, 32'h0000_0088);
        word("rf.pass", 4'd0, CSR, 1'b0, '0, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);

        abort_word(32'h888, 3);
        irq_chk("rst.mid", 1'b0, 4'd0);
        rd_csr("rst.mid.mie", IE, 32'h0000_0000);
        rd_csr("rst.mid.mstatus", MS, 32'h0000_1800);
        rd_csr("rst.mid.mip", IP, 32'h0000_0000);
        rd_csr("rst.mid.mcause", MC, 32'h0000_000B);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
